ps2_keyboard_rx: RTL and testbench

- Receives PS/2 keyboard frames on the ps2_clk/ps2_data pins and produces the scan code byte (tasta) plus a done strobe for the game FSM.
- Filters the keyboard lines, checks start, parity and stop bits, and recovers from aborted frames with a timeout.
- Suppresses break sequences (F0 xx) and E0 prefixes, so only make codes are delivered.
- Sits between the board pins and the game FSM, in the same clock domain as the VGA pixel clock.

---
 rtl/ps2_pkg.sv | 43 ++++
 rtl/ps2_input_filter.sv | 71 +++++++
 rtl/ps2_keyboard_rx.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//   Shared definitions for the PS/2 keyboard receiver and the game FSM that
//   consumes its scan codes.
//   - ps2_state_e : frame FSM state encodings
//   - PS2_BREAK / PS2_EXT : protocol prefix bytes
//   - KEY_* : make codes the game reacts to
//   - odd_parity_ok() : frame parity check
//   - is_game_key() : classifies a make code for the game FSM
// ---------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   localparam logic [7:0] KEY_A     = 8'h1C;
   localparam logic [7:0] KEY_D     = 8'h23;
   localparam logic [7:0] KEY_J     = 8'h3B;
   localparam logic [7:0] KEY_L     = 8'h4B;
   localparam logic [7:0] KEY_1     = 8'h16;
   localparam logic [7:0] KEY_2     = 8'h1E;
   localparam logic [7:0] KEY_SPACE = 8'h29;
   localparam logic [7:0] KEY_ESC   = 8'h76;

   // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

   function automatic logic is_game_key(input logic [7:0] code);
      return (code == KEY_A) || (code == KEY_D) || (code == KEY_J) ||
             (code == KEY_L) || (code == KEY_1) || (code == KEY_2) ||
             (code == KEY_SPACE) || (code == KEY_ESC);
   endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// ---------------------------------------------------------------------------
// ps2_input_filter
//   Conditions the asynchronous PS/2 pins for the frame FSM.
//   Ports:
//     clock, reset     : system clock, asynchronous active-low reset
//     ps2_clk, ps2_data: raw keyboard pins (asynchronous)
//     clk_fall         : one-clock pulse on each accepted falling edge of ps2_clk
//     data_s           : synchronized ps2_data, valid to sample with clk_fall
// ---------------------------------------------------------------------------
module ps2_input_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic clk_fall,
   output logic data_s
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic [1:0]    clk_sync_q, clk_sync_d;
   logic [1:0]    data_sync_q, data_sync_d;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          clk_fall_q, clk_fall_d;

   always_comb begin
      clk_sync_d  = {clk_sync_q[0], ps2_clk};
      data_sync_d = {data_sync_q[0], ps2_data};
      filt_d      = filt_q;
      cnt_d       = '0;
      // The filtered level only follows the synchronized clock after it has
      // disagreed for FILTER_LEN consecutive samples; any agreeing sample
      // restarts the count, so short glitches never reach the FSM.
      if (clk_sync_q[1] != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_d = clk_sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      clk_fall_d = filt_q & ~filt_d;
   end

   // Lines idle high, so the synchronizers and filter start at 1: releasing
   // reset with the keyboard idle can never look like a falling edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         filt_q      <= 1'b1;
         cnt_q       <= '0;
         clk_fall_q  <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         filt_q      <= filt_d;
         cnt_q       <= cnt_d;
         clk_fall_q  <= clk_fall_d;
      end
   end

   assign clk_fall = clk_fall_q;
   // Data is held stable by the keyboard around the falling edge for far
   // longer than the filter delay, so the plain synchronized level suffices.
   assign data_s   = data_sync_q[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_rx
//   PS/2 keyboard receiver: frames bytes off the keyboard lines, drops E0
//   prefixes and break sequences (F0 xx), and hands make codes to the game FSM
//   with a long done strobe.
//   Ports:
//     clock        : system / pixel clock
//     reset        : asynchronous, active-low
//     ps2_clk      : keyboard clock pin (asynchronous)
//     ps2_data     : keyboard data pin (asynchronous)
//     tasta[7:0]   : last delivered make code
//     done         : high for DONE_HOLD clocks after each delivery
//     frame_error  : one-clock pulse on start/parity/stop/timeout failure
// ---------------------------------------------------------------------------
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 25000,
   parameter int DONE_HOLD      = 65535
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] tasta,
   output logic       done,
   output logic       frame_error
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_VAL = HW'(DONE_HOLD);

   logic clk_fall;
   logic data_s;

   ps2_input_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_input_filter (
      .clock    (clock),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .clk_fall (clk_fall),
      .data_s   (data_s)
   );

   // ---------------- frame FSM ----------------
   ps2_state_e    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          byte_valid_q, byte_valid_d;
   logic          frame_error_q, frame_error_d;

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shreg_d       = shreg_q;
      parity_d      = parity_q;
      to_cnt_d      = '0;
      byte_valid_d  = 1'b0;
      frame_error_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (clk_fall) begin
               if (!data_s) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end else begin
                  frame_error_d = 1'b1;
               end
            end
         end
         DATA: begin
            if (clk_fall) begin
               // LSB arrives first, so shift right and enter at the top.
               shreg_d   = {data_s, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (clk_fall) begin
               parity_d = data_s;
               state_d  = STOP;
            end
         end
         STOP: begin
            if (clk_fall) begin
               state_d = IDLE;
               if (data_s && odd_parity_ok(shreg_q, parity_q)) begin
                  byte_valid_d = 1'b1;
               end else begin
                  frame_error_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Any clock edge restarts the idle count; a stalled frame is abandoned.
      // Edges and timeout are mutually exclusive, so the case above never
      // collides with this abort.
      if (state_q != IDLE && !clk_fall) begin
         if (to_cnt_q == TO_LAST) begin
            state_d       = IDLE;
            frame_error_d = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         shreg_q       <= '0;
         parity_q      <= 1'b0;
         to_cnt_q      <= '0;
         byte_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shreg_q       <= shreg_d;
         parity_q      <= parity_d;
         to_cnt_q      <= to_cnt_d;
         byte_valid_q  <= byte_valid_d;
         frame_error_q <= frame_error_d;
      end
   end

   // ---------------- code filter and done stretcher ----------------
   logic          deliver;
   logic          break_pending_q, break_pending_d;
   logic [7:0]    tasta_q, tasta_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          done_q, done_d;
   logic          reload_q, reload_d;

   // shreg_q still holds the completed byte while byte_valid_q is high: the
   // next frame cannot shift anything in for many clocks.
   always_comb begin
      deliver         = 1'b0;
      break_pending_d = break_pending_q;
      if (byte_valid_q) begin
         if (shreg_q == PS2_BREAK) begin
            break_pending_d = 1'b1;
         end else if (shreg_q != PS2_EXT) begin
            if (break_pending_q) begin
               break_pending_d = 1'b0;
            end else begin
               deliver = 1'b1;
            end
         end
      end
   end

   always_comb begin
      tasta_d    = tasta_q;
      hold_cnt_d = hold_cnt_q;
      done_d     = done_q;
      reload_d   = 1'b0;
      if (deliver) begin
         tasta_d = shreg_q;
         if (done_q) begin
            // Drop done for one clock so an edge-triggered consumer sees
            // the second key; the hold is restarted on the following clock.
            done_d     = 1'b0;
            hold_cnt_d = '0;
            reload_d   = 1'b1;
         end else begin
            done_d     = 1'b1;
            hold_cnt_d = HOLD_VAL;
         end
      end else if (reload_q) begin
         done_d     = 1'b1;
         hold_cnt_d = HOLD_VAL;
      end else if (hold_cnt_q != '0) begin
         hold_cnt_d = hold_cnt_q - HW'(1);
         done_d     = (hold_cnt_q != HW'(1));
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         break_pending_q <= 1'b0;
         tasta_q         <= 8'h00;
         hold_cnt_q      <= '0;
         done_q          <= 1'b0;
         reload_q        <= 1'b0;
      end else begin
         break_pending_q <= break_pending_d;
         tasta_q         <= tasta_d;
         hold_cnt_q      <= hold_cnt_d;
         done_q          <= done_d;
         reload_q        <= reload_d;
      end
   end

   assign tasta       = tasta_q;
   assign done        = done_q;
   assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_keyboard_rx
//   Directed bench for ps2_keyboard_rx with shortened timing parameters.
//   PS/2 bit period is 40 system clocks (20 high, 20 low).
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_rx;

   localparam int FL   = 8;
   localparam int TO   = 400;
   localparam int HOLD = 1000;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] tasta;
   logic       done;
   logic       frame_error;

   ps2_keyboard_rx #(
      .FILTER_LEN     (FL),
      .TIMEOUT_CYCLES (TO),
      .DONE_HOLD      (HOLD)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .tasta       (tasta),
      .done        (done),
      .frame_error (frame_error)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // monitor state
   int cyc = 0;
   int done_rises = 0;
   int ferr_cnt = 0;
   int ferr_long = 0;
   int rise_cyc = 0;
   int fall_cyc = 0;
   int high_len = 0;
   int low_len = 0;
   int ferr_cyc = 0;
   logic done_prev = 1'b0;
   logic ferr_prev = 1'b0;
   int last_fall = 0;

   always @(negedge clock) begin
      if (done && !done_prev) begin
         done_rises <= done_rises + 1;
         low_len    <= cyc - fall_cyc;
         rise_cyc   <= cyc;
      end
      if (!done && done_prev) begin
         fall_cyc <= cyc;
         high_len <= cyc - rise_cyc;
      end
      if (frame_error) begin
         ferr_cnt <= ferr_cnt + 1;
         ferr_cyc <= cyc;
         if (ferr_prev) ferr_long <= ferr_long + 1;
      end
      done_prev <= done;
      ferr_prev <= frame_error;
      cyc       <= cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Sends the first nbits bits of a frame; glitch adds short pulses on
   // ps2_clk during bits 2 and 5 that the receiver must ignore.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
      logic [10:0] fr;
      logic        par;
      par = (~^b) ^ bad_par;
      fr  = {1'b1, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         if (glitch && (i == 2 || i == 5)) begin
            wait_clk(3); ps2_clk = 1'b0; wait_clk(3); ps2_clk = 1'b1; wait_clk(4);
         end else begin
            wait_clk(10);
         end
         ps2_clk   = 1'b0;
         last_fall = cyc;
         if (glitch && (i == 2 || i == 5)) begin
            wait_clk(8); ps2_clk = 1'b1; wait_clk(3); ps2_clk = 1'b0; wait_clk(9);
         end else begin
            wait_clk(20);
         end
         ps2_clk = 1'b1;
         wait_clk(10);
      end
      ps2_data = 1'b1;
      wait_clk(20);
      $display("frame %02h bits=%0d bad_par=%0d glitch=%0d -> tasta=%02h done=%0d ferr_total=%0d",
               b, nbits, bad_par, glitch, tasta, done, ferr_cnt);
   endtask

   initial begin
      int base_r;
      int base_e;
      int lat;
      int k;

      // reset state
      reset = 1'b0;
      wait_clk(5);
      check_eq("rst_tasta", tasta, 8'h00);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_ferr", frame_error, 1'b0);
      reset = 1'b1;
      wait_clk(30);
      check_eq("idle_no_ferr", ferr_cnt, 0);

      // 1: valid 0x29, latency and hold length
      base_r = done_rises;
      send_frame(8'h29, 1'b0, 11, 1'b0);
      check_eq("k29_tasta", tasta, 8'h29);
      check_eq("k29_done", done, 1'b1);
      check_eq("k29_rise", done_rises, base_r + 1);
      lat = rise_cyc - last_fall;
      check_eq("k29_latency_ok", (lat >= FL && lat <= FL + 10), 1'b1);
      check_eq("k29_no_ferr", ferr_cnt, 0);
      wait_clk(HOLD + 50);
      check_eq("k29_done_drop", done, 1'b0);
      check_eq("k29_hold_len", high_len, HOLD);

      // 2: 1C, F0 1C -> one delivery; break_pending cleared afterwards
      base_r = done_rises;
      send_frame(8'h1C, 1'b0, 11, 1'b0);
      check_eq("a_tasta", tasta, 8'h1C);
      send_frame(8'hF0, 1'b0, 11, 1'b0);
      send_frame(8'h1C, 1'b0, 11, 1'b0);
      check_eq("brk_rises", done_rises, base_r + 1);
      check_eq("brk_tasta", tasta, 8'h1C);
      wait_clk(HOLD + 50);
      send_frame(8'h1E, 1'b0, 11, 1'b0);
      check_eq("post_brk_tasta", tasta, 8'h1E);
      check_eq("post_brk_rise", done_rises, base_r + 2);
      wait_clk(HOLD + 50);

      // 3: parity error
      base_r = done_rises;
      base_e = ferr_cnt;
      send_frame(8'h23, 1'b1, 11, 1'b0);
      check_eq("par_ferr", ferr_cnt, base_e + 1);
      check_eq("par_ferr_1clk", ferr_long, 0);
      check_eq("par_tasta", tasta, 8'h1E);
      check_eq("par_no_rise", done_rises, base_r);

      // 4: aborted frame -> timeout, then 0x76
      base_e = ferr_cnt;
      send_frame(8'h3B, 1'b0, 5, 1'b0);
      k = 0;
      while (k < TO + 100 && ferr_cnt == base_e) begin
         wait_clk(1);
         k++;
      end
      wait_clk(2);
      check_eq("to_ferr", ferr_cnt, base_e + 1);
      lat = ferr_cyc - last_fall;
      check_eq("to_latency_ok", (lat >= TO && lat <= TO + 25), 1'b1);
      base_r = done_rises;
      send_frame(8'h76, 1'b0, 11, 1'b0);
      check_eq("to_esc_tasta", tasta, 8'h76);
      check_eq("to_esc_rise", done_rises, base_r + 1);

      // 5: glitches on ps2_clk
      base_r = done_rises;
      base_e = ferr_cnt;
      send_frame(8'h4B, 1'b0, 11, 1'b1);
      check_eq("gl_tasta", tasta, 8'h4B);
      check_eq("gl_no_ferr", ferr_cnt, base_e);
      check_eq("gl_rise", done_rises, base_r + 1);
      wait_clk(HOLD + 50);

      // 6: E0 dropped, 75 delivered, 16 within hold -> one-clock low gap
      base_r = done_rises;
      send_frame(8'hE0, 1'b0, 11, 1'b0);
      check_eq("ext_no_rise", done_rises, base_r);
      check_eq("ext_tasta", tasta, 8'h4B);
      send_frame(8'h75, 1'b0, 11, 1'b0);
      check_eq("ext_75_tasta", tasta, 8'h75);
      check_eq("ext_75_rise", done_rises, base_r + 1);
      send_frame(8'h16, 1'b0, 11, 1'b0);
      check_eq("re_tasta", tasta, 8'h16);
      check_eq("re_rise", done_rises, base_r + 2);
      check_eq("re_low_len", low_len, 1);
      check_eq("re_done", done, 1'b1);

      // 7: reset mid-frame
      send_frame(8'h5A, 1'b0, 4, 1'b0);
      reset = 1'b0;
      wait_clk(3);
      check_eq("mrst_tasta", tasta, 8'h00);
      check_eq("mrst_done", done, 1'b0);
      check_eq("mrst_ferr", frame_error, 1'b0);
      base_r = done_rises;
      base_e = ferr_cnt;
      reset = 1'b1;
      wait_clk(TO + 50);
      check_eq("mrst_no_ferr", ferr_cnt, base_e);
      check_eq("mrst_no_rise", done_rises, base_r);
      send_frame(8'h1C, 1'b0, 11, 1'b0);
      check_eq("mrst_recover", tasta, 8'h1C);
      check_eq("mrst_recover_rise", done_rises, base_r + 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
